// File: rtl/reg_bank_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_bank_write_arbiter_if
// Bundles the requester handshake, the shared write bus and the bank read
// port of reg_bank_write_arbiter.
//   req      [NUM_REQ]    per-requester level request, held until granted
//   addr     [2*NUM_REQ]  per-requester register index, lane i = [2i+1:2i]
//   wdata    [8*NUM_REQ]  per-requester write data,     lane i = [8i+7:8i]
//   gnt      [NUM_REQ]    registered one-hot grant, one cycle per transfer
//   busy                  high while a grant is being served
//   rd_addr  [2]          bank read index
//   rd_data  [8]          combinational bank[rd_addr]
//   wr_count [8]          number of committed writes (wrapping)
// master = requester/reader side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface reg_bank_write_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [2*NUM_REQ-1:0] addr;
   logic [8*NUM_REQ-1:0] wdata;
   logic [NUM_REQ-1:0]   gnt;
   logic                 busy;
   logic [1:0]           rd_addr;
   logic [7:0]           rd_data;
   logic [7:0]           wr_count;

   modport master (
      output req, addr, wdata, rd_addr,
      input  gnt, busy, rd_data, wr_count
   );

   modport slave (
      input  req, addr, wdata, rd_addr,
      output gnt, busy, rd_data, wr_count
   );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_write_arbiter
// Round-robin write arbiter in front of a 4 x 8-bit register bank.
// Each transfer takes two cycles: IDLE picks a winner, GRANT pulses gnt and
// commits the write at the edge that ends it (only if the winner still
// requests). The bank is read combinationally through rd_addr/rd_data.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      reg_bank_write_arbiter_if.slave (req/addr/wdata in,
//            gnt/busy out, rd_addr in, rd_data/wr_count out)
// ---------------------------------------------------------------------------
module reg_bank_write_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   reg_bank_write_arbiter_if.slave   bus
);
   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t               state_q;
   logic [IDXW-1:0]      ptr_q;
   logic [IDXW-1:0]      win_q;
   logic [IDXW-1:0]      win_d;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [NUM_REQ-1:0]   gnt_d;
   logic                 busy_q;
   logic [7:0]           bank_q [4];
   logic [7:0]           wr_count_q;

   logic                 any_req_s;
   logic                 found_s;
   logic                 win_req_s;
   logic [1:0]           win_addr_s;
   logic [7:0]           win_wdata_s;

   assign any_req_s = |bus.req;

   // Lane of the latched winner; index scaled by concatenation (x2, x8).
   assign win_req_s   = bus.req[win_q];
   assign win_addr_s  = bus.addr[{win_q, 1'b0} +: 2];
   assign win_wdata_s = bus.wdata[{win_q, 3'b000} +: 8];

   // Round-robin search starting one past the last committed requester.
   always_comb begin
      int unsigned idx_v;
      idx_v   = 0;
      win_d   = ptr_q;
      found_s = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_v = (int'(ptr_q) + k) % NUM_REQ;
         if (!found_s && bus.req[idx_v]) begin
            found_s = 1'b1;
            win_d   = IDXW'(idx_v);
         end else begin
            found_s = found_s;
         end
      end
      gnt_d        = {NUM_REQ{1'b0}};
      gnt_d[win_d] = 1'b1;
   end

   // Arbitration FSM, grant/busy outputs, bank storage and write counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= IDXW'(NUM_REQ - 1);
         win_q      <= {IDXW{1'b0}};
         gnt_q      <= {NUM_REQ{1'b0}};
         busy_q     <= 1'b0;
         wr_count_q <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            bank_q[i] <= 8'h00;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req_s) begin
                  win_q   <= win_d;
                  gnt_q   <= gnt_d;
                  busy_q  <= 1'b1;
                  state_q <= ST_GRANT;
               end else begin
                  gnt_q   <= {NUM_REQ{1'b0}};
                  busy_q  <= 1'b0;
               end
            end
            ST_GRANT: begin
               // A winner that dropped req during its grant is a protocol
               // violation: the slot is spent but nothing is written.
               if (win_req_s) begin
                  bank_q[win_addr_s] <= win_wdata_s;
                  wr_count_q         <= wr_count_q + 8'd1;
                  ptr_q              <= win_q;
               end
               gnt_q   <= {NUM_REQ{1'b0}};
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               gnt_q   <= {NUM_REQ{1'b0}};
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.busy     = busy_q;
   assign bus.wr_count = wr_count_q;
   assign bus.rd_data  = bank_q[bus.rd_addr];

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_write_arbiter
// Directed stimulus with hand-computed expectations. Every expected grant is
// queued when its request is issued; a monitor forked from the main process
// pops and checks the grant on every cycle gnt is high, and checks wr_count
// one cycle later. Bank contents are read back through the read port.
// ---------------------------------------------------------------------------
module tb_reg_bank_write_arbiter;
   localparam int NUM_REQ = 4;

   logic clk;
   logic reset_n;

   reg_bank_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   reg_bank_write_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [3:0] gnt;
      logic [7:0] cnt;
   } exp_t;

   exp_t       exp_q [$];
   exp_t       mon_e;
   logic       mon_pend;
   logic [7:0] mon_cnt;
   int         gtimes [$];
   int         errors;
   int         checks;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [1:0] a, input logic [7:0] d);
      bus.addr[2*i +: 2]  = a;
      bus.wdata[8*i +: 8] = d;
   endtask

   task automatic push(input logic [3:0] g, input logic [7:0] c);
      exp_t e;
      e.gnt = g;
      e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] v);
      bus.rd_addr = a;
      #1;
      chk(name, 32'(bus.rd_data), 32'(v));
   endtask

   // Requesters that follow the rule: each drops req the cycle after its gnt.
   task automatic drop_run(input int n);
      logic [3:0] prev;
      prev = 4'b0000;
      gtimes.delete();
      for (int k = 0; k < n; k++) begin
         tick();
         bus.req = bus.req & ~prev;
         prev    = bus.gnt;
         if (bus.gnt != 4'b0000) gtimes.push_back(k);
      end
   endtask

   initial begin
      logic [3:0] prev;
      logic [7:0] nxt0;
      logic [7:0] nxt3;
      int         seen;
      logic       done;

      errors      = 0;
      checks      = 0;
      mon_pend    = 1'b0;
      mon_cnt     = 8'h00;
      reset_n     = 1'b0;
      bus.req     = 4'b0000;
      bus.addr    = 8'h00;
      bus.wdata   = 32'h0;
      bus.rd_addr = 2'd0;

      fork
         forever begin
            @(negedge clk);
            if (mon_pend) begin
               chk("wr_count_after_gnt", 32'(bus.wr_count), 32'(mon_cnt));
               mon_pend = 1'b0;
            end
            if (bus.gnt != 4'b0000) begin
               chk("busy_with_gnt", 32'(bus.busy), 32'd1);
               if (exp_q.size() == 0) begin
                  chk("unexpected_gnt", 32'(bus.gnt), 32'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("gnt_order", 32'(bus.gnt), 32'(mon_e.gnt));
                  mon_pend = 1'b1;
                  mon_cnt  = mon_e.cnt;
               end
            end else begin
               chk("busy_idle", 32'(bus.busy), 32'd0);
            end
         end
      join_none

      // Reset state and read sweep.
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      tick();
      for (int a = 0; a < 4; a++) rd_chk("reset_bank", 2'(a), 8'h00);
      chk("reset_gnt", 32'(bus.gnt), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_wr_count", 32'(bus.wr_count), 32'd0);

      // Single write: requester 2 -> bank[1] = A5.
      tick();
      bus.req = 4'b0100;
      set_lane(2, 2'd1, 8'hA5);
      push(4'b0100, 8'd1);
      tick();
      chk("single_gnt", 32'(bus.gnt), 32'(4'b0100));
      tick();
      bus.req = 4'b0000;
      chk("single_gnt_one_cycle", 32'(bus.gnt), 32'd0);
      rd_chk("single_bank1", 2'd1, 8'hA5);
      chk("single_wr_count", 32'(bus.wr_count), 32'd1);

      // Contention from reset: grants 0,1,2,3 two cycles apart.
      repeat (2) tick();
      reset_n = 1'b0;
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) set_lane(i, 2'(i), 8'h10 + 8'(i));
      push(4'b0001, 8'd1);
      push(4'b0010, 8'd2);
      push(4'b0100, 8'd3);
      push(4'b1000, 8'd4);
      @(negedge clk);
      #1 reset_n = 1'b1;
      drop_run(12);
      chk("contention_grant_count", 32'(gtimes.size()), 32'd4);
      if (gtimes.size() == 4) begin
         for (int i = 0; i < 3; i++)
            chk("contention_spacing", 32'(gtimes[i+1] - gtimes[i]), 32'd2);
      end
      for (int a = 0; a < 4; a++) rd_chk("contention_bank", 2'(a), 8'h10 + 8'(a));
      chk("contention_wr_count", 32'(bus.wr_count), 32'd4);

      // Fairness: requesters 0 and 3 continuously busy; must alternate.
      repeat (2) tick();
      nxt0 = 8'h20;
      nxt3 = 8'h30;
      set_lane(0, 2'd0, nxt0);
      set_lane(3, 2'd2, nxt3);
      bus.req = 4'b1001;
      push(4'b0001, 8'd5);
      push(4'b1000, 8'd6);
      push(4'b0001, 8'd7);
      push(4'b1000, 8'd8);
      prev = 4'b0000;
      seen = 0;
      done = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!done) begin
            tick();
            if (prev != 4'b0000) begin
               if (seen == 4) begin
                  bus.req = 4'b0000;
                  done    = 1'b1;
               end else begin
                  if (prev[0]) begin nxt0 = nxt0 + 8'd1; set_lane(0, 2'd0, nxt0); end
                  if (prev[3]) begin nxt3 = nxt3 + 8'd1; set_lane(3, 2'd2, nxt3); end
               end
            end
            prev = bus.gnt;
            if (prev != 4'b0000) seen++;
         end
      end
      bus.req = 4'b0000;
      chk("fair_grant_count", 32'(seen), 32'd4);
      rd_chk("fair_bank0", 2'd0, 8'h21);
      rd_chk("fair_bank2", 2'd2, 8'h31);
      rd_chk("fair_bank3", 2'd3, 8'h13);
      chk("fair_wr_count", 32'(bus.wr_count), 32'd8);

      // Violation: requester 1 drops req during its grant.
      repeat (2) tick();
      set_lane(1, 2'd1, 8'hEE);
      bus.req = 4'b0010;
      push(4'b0010, 8'd8);
      tick();
      bus.req = 4'b0000;
      tick();
      rd_chk("viol_bank1", 2'd1, 8'h11);
      chk("viol_wr_count", 32'(bus.wr_count), 32'd8);

      // Asynchronous reset in the middle of a grant.
      repeat (2) tick();
      set_lane(2, 2'd3, 8'h77);
      bus.req = 4'b0100;
      push(4'b0100, 8'd0);
      tick();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_gnt", 32'(bus.gnt), 32'd0);
      chk("areset_busy", 32'(bus.busy), 32'd0);
      chk("areset_wr_count", 32'(bus.wr_count), 32'd0);
      for (int a = 0; a < 4; a++) rd_chk("areset_bank", 2'(a), 8'h00);
      set_lane(0, 2'd0, 8'h5A);
      bus.req = 4'b0101;
      push(4'b0001, 8'd1);
      push(4'b0100, 8'd2);
      @(negedge clk);
      #1 reset_n = 1'b1;
      drop_run(8);
      rd_chk("post_reset_bank0", 2'd0, 8'h5A);
      rd_chk("post_reset_bank3", 2'd3, 8'h77);
      chk("post_reset_wr_count", 32'(bus.wr_count), 32'd2);

      repeat (3) tick();
      chk("expected_grants_left", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Round-robin write arbiter and sequencer for a small bank of 8-bit registers built from the team's D flip-flop register cells. Up to NUM_REQ requesters share one write port into a 4-entry 8-bit register bank. The block grants one requester at a time with a req/gnt handshake, commits the granted write, and exposes the bank through a combinational read port. It sits between the datapath units that produce results and the shared register storage.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  reset, asynchronous, active-low; clears all state immediately.
- req  input  NUM_REQ  per-requester write request; level, held until granted.
- addr  input  2*NUM_REQ  per-requester target register index; lane i is bits [2i+1:2i].
- wdata  input  8*NUM_REQ  per-requester write data; lane i is bits [8i+7:8i].
- gnt  output  NUM_REQ  registered one-hot grant; high for exactly one cycle per granted transfer.
- busy  output  1  high while in GRANT state.
- rd_addr  input  2  read index.
- rd_data  output  8  combinational bank[rd_addr].
- wr_count  output  8  number of committed writes, wraps 255 -> 0.

## Operation
- States: IDLE, GRANT.
- IDLE: if any req bit is high, select the winner by round-robin search starting at index (ptr+1) mod NUM_REQ, then upward with wrap. Latch the winner index and go to GRANT. If no req bit is high, stay in IDLE.
- GRANT: gnt[win]=1 and busy=1. At the edge ending GRANT:
  - If req[win] is still high: bank[addr lane win] <= wdata lane win, wr_count += 1, ptr <= win.
  - If req[win] has dropped (protocol violation): no write, no count, ptr unchanged.
  - In either case, go to IDLE.
- Requester rule: hold req, addr and wdata stable from assertion through the GRANT cycle. Deassert req, or present the next transfer, starting in the cycle after gnt.
- The arbiter ignores req in the cycle after GRANT only if the requester followed the rule. Otherwise a still-high req is a new request.
- Reset values: state IDLE, gnt 0, busy 0, all bank entries 8'h00, wr_count 0, ptr NUM_REQ-1 (so requester 0 has first priority after reset).
- Reset mid-operation: an in-flight GRANT is abandoned with no write, and gnt drops asynchronously.
- rd_data reflects the bank contents after each edge. There is no read/write bypass.

## Timing
- Edge e0: req sampled high in IDLE. gnt high in the cycle after e0. Write committed at edge e1. rd_data shows the new value in the cycle after e1.
- Request-to-gnt latency: 1 cycle. Request-to-visible-data latency: 2 cycles.
- Throughput: one write per 2 cycles. Under continuous contention from all requesters, each one is granted once every 2*NUM_REQ cycles.
- gnt and busy are registered, glitch-free and never overlap for two requesters.
- Simultaneous requests to the same address in different grants: the later grant's data wins.

## Test plan
- Reset, then idle, then rd_addr sweep 0..3: rd_data = 8'h00 for every address, gnt=0, busy=0, wr_count=0.
- Single write: req[2] with addr 2'd1 and wdata 8'hA5, held until gnt. gnt=4'b0100 exactly one cycle after sampling; the following cycle bank[1]=8'hA5 and wr_count=1.
- Contention: all four req high from reset, each dropped after its gnt, data 8'h10/11/12/13 to addresses 0/1/2/3. Grants occur in order 0,1,2,3, spaced 2 cycles apart. Final bank = 10,11,12,13 and wr_count=4.
- Fairness: req[0] and req[3] held high continuously, with addr/wdata changed after each gnt. Grants alternate 0,3,0,3 and neither starves.
- Violation: req[1] drops during its GRANT cycle. gnt[1] still pulses, the bank is unchanged and wr_count is unchanged.
- Async reset: reset_n pulled low mid-GRANT. gnt drops immediately and the bank and wr_count read 0. After release, requester 0 is granted first.
